// File: rtl/ifu_icache_refill.sv
// ---------------------------------------------------------------------------
// ifu_icache_refill
//
// Miss-refill engine for the 2-way, 32KB instruction cache. The cache has
// 512 sets, and each 256-bit line is split into two 128-bit banks.
//
// Behaviour:
//   - Accepts one miss at a time.
//   - Issues a single line read to the bus.
//   - Writes the two returned beats into bank 0 and bank 1 of the victim way.
//   - Writes the tag (with valid) together with the final beat only. A line
//     that is only partly written can therefore never hit.
//
// Optional feature (macro ICACHE_REFILL_BYPASS_EN):
//   When defined, byp_valid/byp_bank/byp_data forward every beat that is
//   being written. Fetch can then use the data without re-reading the array.
//   When not defined, those ports are absent.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   miss_req/addr/way   miss request from lookup (line address [31:5], victim way)
//   miss_ready          engine idle; miss taken on miss_req & miss_ready
//   kill                abort current refill (pipeline flush)
//   mem_req_*           line read request to bus (valid/ready handshake)
//   mem_resp_*          beats from bus (no backpressure, beat0 then beat1)
//   dary_*              data array write port (way, bank, index, data)
//   tag_*               tag/valid array write port
//   refill_done         one-cycle pulse after the line is installed
//   byp_*               (optional) beat forwarding to fetch
// ---------------------------------------------------------------------------
module ifu_icache_refill #(
    parameter int TAG_W  = 18,
    parameter int IDX_W  = 9,
    parameter int BEAT_W = 128
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   miss_req,
    input  logic [TAG_W+IDX_W-1:0] miss_addr,
    input  logic                   miss_way,
    output logic                   miss_ready,
    input  logic                   kill,

    output logic                   mem_req_valid,
    output logic [TAG_W+IDX_W-1:0] mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [BEAT_W-1:0]      mem_resp_data,

    output logic                   dary_wen,
    output logic                   dary_way,
    output logic                   dary_bank,
    output logic [IDX_W-1:0]       dary_idx,
    output logic [BEAT_W-1:0]      dary_wdata,

    output logic                   tag_wen,
    output logic                   tag_way,
    output logic [IDX_W-1:0]       tag_idx,
    output logic [TAG_W-1:0]       tag_wdata,

`ifdef ICACHE_REFILL_BYPASS_EN
    output logic                   byp_valid,
    output logic                   byp_bank,
    output logic [BEAT_W-1:0]      byp_data,
`endif

    output logic                   refill_done
);

    localparam int LADDR_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_BEAT0,
        S_BEAT1,
        S_DRAIN0,   // both beats still owed by the bus, discard them
        S_DRAIN1    // one beat still owed by the bus, discard it
    } state_t;

    state_t               state_q, state_d;
    logic [LADDR_W-1:0]   addr_q,  addr_d;
    logic                 way_q,   way_d;
    logic                 done_q,  done_d;

    logic                 wen_c;
    logic                 bank_c;
    logic                 tag_wen_c;
    logic                 req_valid_c;
    logic                 ready_c;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            way_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            way_q   <= way_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        way_d       = way_q;
        done_d      = 1'b0;
        wen_c       = 1'b0;
        bank_c      = 1'b0;
        tag_wen_c   = 1'b0;
        req_valid_c = 1'b0;
        ready_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done pulse cycle still belongs to the old refill.
                // A new miss is taken from the following cycle.
                ready_c = ~done_q;
                if (miss_req && ready_c && !kill) begin
                    addr_d  = miss_addr;
                    way_d   = miss_way;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                req_valid_c = 1'b1;
                if (kill) begin
                    // If the handshake happens in the kill cycle, the bus
                    // owes us the full line, so it must be drained.
                    state_d = mem_req_ready ? S_DRAIN0 : S_IDLE;
                end else if (mem_req_ready) begin
                    state_d = S_BEAT0;
                end
            end

            S_BEAT0: begin
                if (kill) begin
                    state_d = mem_resp_valid ? S_DRAIN1 : S_DRAIN0;
                end else if (mem_resp_valid) begin
                    wen_c   = 1'b1;
                    state_d = S_BEAT1;
                end
            end

            S_BEAT1: begin
                if (kill) begin
                    // A beat arriving in the kill cycle is the last one owed.
                    state_d = mem_resp_valid ? S_IDLE : S_DRAIN1;
                end else if (mem_resp_valid) begin
                    wen_c     = 1'b1;
                    bank_c    = 1'b1;
                    tag_wen_c = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_DRAIN0: begin
                if (mem_resp_valid) begin
                    state_d = S_DRAIN1;
                end
            end

            S_DRAIN1: begin
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output mapping. Index and tag come from the registered line address.
    // Write data is forced to zero when no write happens, so the data port
    // stays quiet outside beat writes.
    // ------------------------------------------------------------------
    assign miss_ready    = ready_c;
    assign mem_req_valid = req_valid_c;
    assign mem_req_addr  = addr_q;

    assign dary_wen      = wen_c;
    assign dary_way      = way_q;
    assign dary_bank     = bank_c;
    assign dary_idx      = addr_q[IDX_W-1:0];
    assign dary_wdata    = wen_c ? mem_resp_data : '0;

    assign tag_wen       = tag_wen_c;
    assign tag_way       = way_q;
    assign tag_idx       = addr_q[IDX_W-1:0];
    assign tag_wdata     = addr_q[LADDR_W-1:IDX_W];

    assign refill_done   = done_q;

`ifdef ICACHE_REFILL_BYPASS_EN
    assign byp_valid     = wen_c;
    assign byp_bank      = bank_c;
    assign byp_data      = dary_wdata;
`endif

endmodule

// File: tb/tb_ifu_icache_refill.sv
// ---------------------------------------------------------------------------
// tb_ifu_icache_refill
//
// Directed testbench for ifu_icache_refill.
//
// Timing:
//   - Inputs are driven 1ns after each rising edge.
//   - Combinational outputs are checked 1ns after that.
//   - A falling-edge monitor counts the write, tag, done and bus-handshake
//     events.
//
// Expected index and tag are taken from the bit fields of miss_addr:
//   index = miss_addr[8:0], tag = miss_addr[26:9].
// ---------------------------------------------------------------------------
module tb_ifu_icache_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [26:0]  miss_addr;
    logic         miss_way;
    logic         miss_ready;
    logic         kill;
    logic         mem_req_valid;
    logic [26:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         dary_wen;
    logic         dary_way;
    logic         dary_bank;
    logic [8:0]   dary_idx;
    logic [127:0] dary_wdata;
    logic         tag_wen;
    logic         tag_way;
    logic [8:0]   tag_idx;
    logic [17:0]  tag_wdata;
    logic         refill_done;
`ifdef ICACHE_REFILL_BYPASS_EN
    logic         byp_valid;
    logic         byp_bank;
    logic [127:0] byp_data;
`endif

    int errors = 0;
    int checks = 0;
    int n_wen  = 0;
    int n_tag  = 0;
    int n_done = 0;
    int n_hs   = 0;

    always #5 clk = ~clk;

    ifu_icache_refill dut (
        .clk            (clk),
        .rst            (rst),
        .miss_req       (miss_req),
        .miss_addr      (miss_addr),
        .miss_way       (miss_way),
        .miss_ready     (miss_ready),
        .kill           (kill),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .dary_wen       (dary_wen),
        .dary_way       (dary_way),
        .dary_bank      (dary_bank),
        .dary_idx       (dary_idx),
        .dary_wdata     (dary_wdata),
        .tag_wen        (tag_wen),
        .tag_way        (tag_way),
        .tag_idx        (tag_idx),
        .tag_wdata      (tag_wdata),
`ifdef ICACHE_REFILL_BYPASS_EN
        .byp_valid      (byp_valid),
        .byp_bank       (byp_bank),
        .byp_data       (byp_data),
`endif
        .refill_done    (refill_done)
    );

    // Event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (dary_wen)                      n_wen  <= n_wen + 1;
        if (tag_wen)                       n_tag  <= n_tag + 1;
        if (refill_done)                   n_done <= n_done + 1;
        if (mem_req_valid & mem_req_ready) n_hs   <= n_hs + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a miss and leave the engine in REQ.
    task automatic accept(input logic [26:0] a, input logic w);
        tick();
        miss_req  = 1'b1;
        miss_addr = a;
        miss_way  = w;
        #1 check("accept_ready", miss_ready, 1);
        tick();
        miss_req  = 1'b0;
        miss_addr = '0;
    endtask

    // Hold the request off for nwait cycles, then complete the handshake.
    task automatic handshake(input int nwait, input logic [26:0] a);
        for (int i = 0; i < nwait; i++) begin
            #1;
            check("req_valid_hold", mem_req_valid, 1);
            check("req_addr_hold", mem_req_addr, a);
            check("no_wen_in_req", dary_wen, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        #1 check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_req_addr, a);
        tick();
        mem_req_ready = 1'b0;
    endtask

    // Deliver one beat that is expected to be written.
    task automatic beat(input logic [127:0] d, input logic bank, input logic last,
                        input logic [26:0] a, input logic w);
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        #1;
        check("beat_wen", dary_wen, 1);
        check("beat_bank", dary_bank, bank);
        check("beat_wdata", dary_wdata, d);
        check("beat_idx", dary_idx, a[8:0]);
        check("beat_way", dary_way, w);
        check("beat_tag_wen", tag_wen, last);
        if (last) begin
            check("tag_wdata", tag_wdata, a[26:9]);
            check("tag_idx", tag_idx, a[8:0]);
            check("tag_way", tag_way, w);
        end
`ifdef ICACHE_REFILL_BYPASS_EN
        check("byp_valid", byp_valid, 1);
        check("byp_bank", byp_bank, bank);
        check("byp_data", byp_data, d);
`endif
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    // Idle cycles on the response bus, with no writes expected.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            #1 check("gap_no_wen", dary_wen, 0);
            tick();
        end
    endtask

    // Called right after the last beat's edge.
    task automatic expect_done();
        #1 check("refill_done", refill_done, 1);
        check("ready_in_done", miss_ready, 0);
        tick();
        check("done_pulse_end", refill_done, 0);
        check("ready_after_done", miss_ready, 1);
    endtask

    localparam logic [26:0] A1 = 27'h2ABCDEF;   // idx 0x1EF, tag 0x155E6
    localparam logic [26:0] A2 = 27'h0123456;   // idx 0x056, tag 0x0091A
    localparam logic [26:0] A3 = 27'h7FFFE00;   // idx 0x000, tag 0x3FFFF
    localparam logic [127:0] DA = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] DB = 128'hDEADBEEF_CAFEF00D_11223344_55667788;

    int s_wen, s_tag, s_done, s_hs;

    task automatic snap();
        s_wen  = n_wen;
        s_tag  = n_tag;
        s_done = n_done;
        s_hs   = n_hs;
    endtask

    initial begin
        rst            = 1'b1;
        miss_req       = 1'b0;
        miss_addr      = '0;
        miss_way       = 1'b0;
        kill           = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick();
        tick();

        // Reset values of all outputs.
        check("rst_miss_ready", miss_ready, 1);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_dary_wen", dary_wen, 0);
        check("rst_dary_idx", dary_idx, 0);
        check("rst_dary_wdata", dary_wdata, 0);
        check("rst_dary_way", dary_way, 0);
        check("rst_tag_wen", tag_wen, 0);
        check("rst_tag_wdata", tag_wdata, 0);
        check("rst_done", refill_done, 0);
        rst = 1'b0;

        // 1) Basic refill, bus ready at once, back-to-back beats.
        snap();
        accept(A1, 1'b1);
        handshake(0, A1);
        beat(DA, 1'b0, 1'b0, A1, 1'b1);
        beat(DB, 1'b1, 1'b1, A1, 1'b1);
        expect_done();
        check("basic_wen_cnt", n_wen - s_wen, 2);
        check("basic_tag_cnt", n_tag - s_tag, 1);

        // 2) Request backpressure for 5 cycles.
        snap();
        accept(A2, 1'b0);
        handshake(5, A2);
        check("bp_no_wen", n_wen - s_wen, 0);
        beat(DB, 1'b0, 1'b0, A2, 1'b0);
        beat(DA, 1'b1, 1'b1, A2, 1'b0);
        expect_done();

        // 3) Three idle cycles between the beats.
        snap();
        accept(A3, 1'b1);
        handshake(0, A3);
        beat(DA, 1'b0, 1'b0, A3, 1'b1);
        gap(3);
        check("gap_no_tag_yet", n_tag - s_tag, 0);
        beat(DB, 1'b1, 1'b1, A3, 1'b1);
        expect_done();
        check("gap_wen_cnt", n_wen - s_wen, 2);
        check("gap_tag_cnt", n_tag - s_tag, 1);

        // 4) Kill in REQ before ready.
        snap();
        accept(A1, 1'b0);
        kill = 1'b1;
        #1 check("kill_req_valid", mem_req_valid, 1);
        tick();
        kill = 1'b0;
        check("kill_req_ready_back", miss_ready, 1);
        check("kill_req_no_valid", mem_req_valid, 0);
        tick();
        check("kill_req_no_hs", n_hs - s_hs, 0);
        check("kill_req_no_wen", n_wen - s_wen, 0);

        // 5) Kill together with miss_req: nothing is captured.
        tick();
        miss_req  = 1'b1;
        miss_addr = A2;
        kill      = 1'b1;
        tick();
        miss_req  = 1'b0;
        kill      = 1'b0;
        check("kill_miss_no_req", mem_req_valid, 0);
        check("kill_miss_ready", miss_ready, 1);

        // 6) Kill after beat0: beat1 is drained without any write.
        snap();
        accept(A2, 1'b1);
        handshake(0, A2);
        beat(DA, 1'b0, 1'b0, A2, 1'b1);
        kill = 1'b1;
        #1 check("kill_b1_no_wen", dary_wen, 0);
        tick();
        kill = 1'b0;
        check("drain_not_ready", miss_ready, 0);
        gap(2);
        check("drain_still_busy", miss_ready, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = DB;
        #1 check("drain_beat_no_wen", dary_wen, 0);
        check("drain_beat_no_tag", tag_wen, 0);
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        check("drain_ready_back", miss_ready, 1);
        check("drain_no_done", refill_done, 0);
        check("kill_b1_wen_cnt", n_wen - s_wen, 1);
        check("kill_b1_tag_cnt", n_tag - s_tag, 0);
        check("kill_b1_done_cnt", n_done - s_done, 0);

        // The next miss then completes normally.
        accept(A1, 1'b0);
        handshake(1, A1);
        beat(DB, 1'b0, 1'b0, A1, 1'b0);
        beat(DA, 1'b1, 1'b1, A1, 1'b0);
        expect_done();

        // 7) Reset asserted in BEAT1, then a stale beat arrives.
        snap();
        accept(A3, 1'b1);
        handshake(0, A3);
        beat(DA, 1'b0, 1'b0, A3, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ready", miss_ready, 1);
        check("rst_mid_req_valid", mem_req_valid, 0);
        check("rst_mid_req_addr", mem_req_addr, 0);
        check("rst_mid_idx", dary_idx, 0);
        check("rst_mid_way", dary_way, 0);
        check("rst_mid_tag_wdata", tag_wdata, 0);
        check("rst_mid_done", refill_done, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = DB;
        #1 check("stale_no_wen", dary_wen, 0);
        check("stale_no_tag", tag_wen, 0);
        check("stale_wdata", dary_wdata, 0);
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick();
        check("rst_mid_wen_cnt", n_wen - s_wen, 1);
        check("rst_mid_tag_cnt", n_tag - s_tag, 0);
        check("rst_mid_done_cnt", n_done - s_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
